ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Clocked arbiter between the pipeline stages and the single-port synchronous ram.
//  Serialises stage12 fetch reads, stage3 load reads and stage5 store writes onto one memory port.
//  Returns read data and a one-cycle ready pulse to the served stage.
//  Fixed priority: stage5 > stage3 > stage12.
// PARAMETERS
//  ADDR_W        16  address width
//  DATA_W        8   data width
//  STARVE_LIMIT  4   consecutive stage12 losses before forced grant (ARB_STARVE_GUARD_EN only)
// PORTS
//  ram_clk     in   1       single clock, all state on posedge
//  rst         in   1       reset, asynchronous, active-high
//  s12_req     in   1       stage12 read request, level, held until s12_ready
//  s12_addr    in   ADDR_W  stage12 read address, stable while s12_req=1
//  s12_ready   out  1       one-cycle pulse, s12_data valid
//  s12_data    out  DATA_W  stage12 read data, held until next stage12 completion
//  s3_req/s3_addr/s3_ready/s3_data   same set for stage3
//  s5_req      in   1       stage5 write request
//  s5_addr     in   ADDR_W  write address
//  s5_wdata    in   DATA_W  write data, stable while s5_req=1
//  s5_ready    out  1       one-cycle pulse, write committed
//  mem_we      out  1       ram write enable
//  mem_addr    out  ADDR_W  ram address
//  mem_wdata   out  DATA_W  ram write data
//  mem_rdata   in   DATA_W  ram read data, registered, valid one cycle after address edge
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; mem_we, all *_ready, all *_data, mem_addr, mem_wdata,
//    starve counter = 0.
//  - IDLE: at posedge, if any unmasked req, latch winner into grant.
//    Drive mem_addr/mem_wdata from the winner; mem_we=1 only for s5. Go to ACCESS. Otherwise stay in IDLE.
//  - ACCESS: ram performs the op at this edge. mem_we<=0. Go to DONE.
//  - DONE: for a read, capture mem_rdata into <grant>_data. Pulse <grant>_ready=1 for exactly
//    one cycle. Go to IDLE.
//  - Latency: req sampled at edge N -> ready high in cycle after edge N+2. Throughput: 1 access/3 cycles.
//  - Mask: in the cycle where X_ready=1, X_req is ignored, so a requester that drops req on
//    seeing ready issues no duplicate access. A req still high one cycle later is a new access.
//  - A req that arrives during ACCESS/DONE waits; there is no queueing beyond the level req.
//  - Simultaneous reqs: the highest priority wins; losers keep req high and are served in later rounds.
//  - Requests hold their addr/wdata stable; a change mid-access is undefined. It is not checked.
//  - Reset mid-access: the in-flight op is abandoned, no ready is issued, and mem_we drops immediately.
//    A write is committed only if the ACCESS edge occurred before reset.
//  - Address wraps naturally at ADDR_W; no range checking.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//   - A counter increments on each grant to s3/s5 while s12_req=1.
//   - When it reaches STARVE_LIMIT, the next IDLE grant goes to s12 regardless of priority.
//   - The counter clears on any s12 grant, or when s12_req=0.
//  ARB_STARVE_GUARD_EN undefined: strict fixed priority; the counter logic is absent.
//   s12 may starve under continuous s3/s5 traffic.
// STRUCTURE
//  - Package ram_arb_pkg holds:
//    - enum arb_state_t {IDLE, ACCESS, DONE};
//    - enum arb_grant_t {GNT_NONE, GNT_S12, GNT_S3, GNT_S5};
//    - default ADDR_W/DATA_W localparams.
//  - Sub-module ram_arb_pick (combinational): inputs are masked reqs and the starve flag;
//    output is arb_grant_t.
//  - Top holds the FSM, grant register, output regs and the starve counter.
// TESTING
//  1. ram[0x0004]=0x02; s12_req, s12_addr=0x0004 at edge 0 -> s12_ready pulse after edge 2,
//     s12_data=0x02.
//  2. s5 write 0x0010<=0xAB, then s3 read 0x0010 -> s5_ready once, then s3_data=0xAB.
//  3. s12, s3, s5 all req at edge 0 and held until served -> grants s5, s3, s12;
//     readies after edges 2, 5, 8.
//  4. rst pulsed during ACCESS of an s3 read -> mem_we=0 immediately, no s3_ready.
//     A fresh s3 req after reset completes normally in 3 cycles.
//  5. s3 re-requests continuously with s12_req=1 -> macro off: no s12_ready;
//     macro on: s12_ready after the 4th s3 grant.
//  6. Requester holds req one cycle past ready -> the ready cycle is masked;
//     exactly one extra access starts only on the following edge.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the pipeline-to-RAM port arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF       = 16;
    localparam int DATA_W_DEF       = 8;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_S12  = 2'd1,
        GNT_S3   = 2'd2,
        GNT_S5   = 2'd3
    } arb_grant_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the three stage request ports and the single RAM port.
// The slave modport is the arbiter's view; master is the stages plus RAM.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              s12_req;
    logic [ADDR_W-1:0] s12_addr;
    logic              s12_ready;
    logic [DATA_W-1:0] s12_data;

    logic              s3_req;
    logic [ADDR_W-1:0] s3_addr;
    logic              s3_ready;
    logic [DATA_W-1:0] s3_data;

    logic              s5_req;
    logic [ADDR_W-1:0] s5_addr;
    logic [DATA_W-1:0] s5_wdata;
    logic              s5_ready;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  s12_req, s12_addr, s3_req, s3_addr, s5_req, s5_addr, s5_wdata, mem_rdata,
        output s12_ready, s12_data, s3_ready, s3_data, s5_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output s12_req, s12_addr, s3_req, s3_addr, s5_req, s5_addr, s5_wdata, mem_rdata,
        input  s12_ready, s12_data, s3_ready, s3_data, s5_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational winner selection: stage5 > stage3 > stage12, unless the
// starvation flag forces stage12 to the front.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic       s12_req,
    input  logic       s3_req,
    input  logic       s5_req,
    input  logic       starve,
    output arb_grant_t grant
);

    // Priority encoder with starvation override
    always_comb begin
        grant = GNT_NONE;
        if (starve && s12_req) begin
            grant = GNT_S12;
        end else if (s5_req) begin
            grant = GNT_S5;
        end else if (s3_req) begin
            grant = GNT_S3;
        end else if (s12_req) begin
            grant = GNT_S12;
        end else begin
            grant = GNT_NONE;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises stage12/stage3 reads and stage5 writes onto one synchronous RAM port.
// Optional starvation guard for stage12 is enabled by defining ARB_STARVE_GUARD_EN.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
`ifdef ARB_STARVE_GUARD_EN
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
`endif
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic                ram_clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   bus
);

    arb_state_t        state_r;
    arb_state_t        state_s;
    arb_grant_t        grant_r;
    arb_grant_t        pick_s;
    logic              starve_s;
    logic              req12_s;
    logic              req3_s;
    logic              req5_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              s12_ready_r;
    logic              s3_ready_r;
    logic              s5_ready_r;
    logic [DATA_W-1:0] s12_data_r;
    logic [DATA_W-1:0] s3_data_r;

    // A requester is ignored in its own ready cycle so a dropping req is not re-served.
    assign req12_s = bus.s12_req & ~s12_ready_r;
    assign req3_s  = bus.s3_req  & ~s3_ready_r;
    assign req5_s  = bus.s5_req  & ~s5_ready_r;

    ram_arb_pick u_pick (
        .s12_req (req12_s),
        .s3_req  (req3_s),
        .s5_req  (req5_s),
        .starve  (starve_s),
        .grant   (pick_s)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt_r;

    assign starve_s = (starve_cnt_r >= CNT_W'(STARVE_LIMIT));

    // Counts stage12 losses; saturates at the limit and clears once stage12 is served or idle
    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!bus.s12_req) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == IDLE && pick_s == GNT_S12) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == IDLE && (pick_s == GNT_S3 || pick_s == GNT_S5) && !starve_s) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end
    end
`else
    assign starve_s = 1'b0;
`endif

    // Address of the stage about to be granted
    always_comb begin
        win_addr_s = mem_addr_r;
        case (pick_s)
            GNT_S12: win_addr_s = bus.s12_addr;
            GNT_S3:  win_addr_s = bus.s3_addr;
            GNT_S5:  win_addr_s = bus.s5_addr;
            default: win_addr_s = mem_addr_r;
        endcase
    end

    // Next-state logic of the IDLE -> ACCESS -> DONE access cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_s != GNT_NONE) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS:  state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant latch, RAM port drive and per-stage data/ready registers
    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            grant_r     <= GNT_NONE;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            s12_ready_r <= 1'b0;
            s3_ready_r  <= 1'b0;
            s5_ready_r  <= 1'b0;
            s12_data_r  <= {DATA_W{1'b0}};
            s3_data_r   <= {DATA_W{1'b0}};
        end else begin
            mem_we_r    <= 1'b0;
            s12_ready_r <= 1'b0;
            s3_ready_r  <= 1'b0;
            s5_ready_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_s != GNT_NONE) begin
                        grant_r    <= pick_s;
                        mem_addr_r <= win_addr_s;
                        mem_we_r   <= (pick_s == GNT_S5);
                        if (pick_s == GNT_S5) begin
                            mem_wdata_r <= bus.s5_wdata;
                        end
                    end
                end
                ACCESS: begin
                    mem_we_r <= 1'b0;
                end
                DONE: begin
                    // RAM output is registered, so read data is valid only now
                    case (grant_r)
                        GNT_S12: begin
                            s12_data_r  <= bus.mem_rdata;
                            s12_ready_r <= 1'b1;
                        end
                        GNT_S3: begin
                            s3_data_r  <= bus.mem_rdata;
                            s3_ready_r <= 1'b1;
                        end
                        GNT_S5:  s5_ready_r <= 1'b1;
                        default: s5_ready_r <= 1'b0;
                    endcase
                end
                default: mem_we_r <= 1'b0;
            endcase
        end
    end

    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.s12_ready = s12_ready_r;
    assign bus.s3_ready  = s3_ready_r;
    assign bus.s5_ready  = s5_ready_r;
    assign bus.s12_data  = s12_data_r;
    assign bus.s3_data   = s3_data_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: stimulus pushes expected readies into a queue, a negedge monitor pops and compares.
module tb_ram_port_arbiter;

    logic ram_clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        int         port;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t q[$];

    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;
    logic [7:0]  ram [0:65535];

    ram_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    ram_port_arbiter dut (
        .ram_clk (ram_clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial ram_clk = 1'b0;
    always #5 ram_clk = ~ram_clk;

    always @(posedge ram_clk) cyc <= cyc + 1;

    // Synchronous RAM model: registered read data, write on mem_we, plus a preload port
    always @(posedge ram_clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push(input int port, input logic [7:0] data, input int at);
        exp_t e;
        e.port = port;
        e.data = data;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic at_neg(input int n);
        while (cyc < n) @(negedge ram_clk);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge ram_clk);
        pre_we   = 1'b0;
    endtask

    // Monitor: every ready pulse must match the next queued expectation
    always @(negedge ram_clk) begin
        int nrdy;
        int port;
        int data;
        exp_t e;
        if (!rst) begin
            nrdy = int'(bus.s12_ready) + int'(bus.s3_ready) + int'(bus.s5_ready);
            if (nrdy > 1) begin
                total++;
                bad++;
                $display("FAIL multi_ready count=%0d required=1 cyc=%0d", nrdy, cyc);
            end
            if (nrdy != 0) begin
                if (bus.s12_ready) begin
                    port = 12;
                    data = int'(bus.s12_data);
                end else if (bus.s3_ready) begin
                    port = 3;
                    data = int'(bus.s3_data);
                end else begin
                    port = 5;
                    data = 0;
                end
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ready port=s%0d cyc=%0d required=none", port, cyc);
                end else begin
                    e = q.pop_front();
                    if (port != e.port || cyc != e.cyc || (port != 5 && data != int'(e.data))) begin
                        bad++;
                        $display("FAIL ready port=s%0d cyc=%0d data=%0h required port=s%0d cyc=%0d data=%0h",
                                 port, cyc, data, e.port, e.cyc, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        cyc = 0; total = 0; bad = 0;
        rst = 1'b1; pre_we = 1'b0; pre_addr = 16'h0000; pre_data = 8'h00;
        bus.s12_req = 1'b0; bus.s12_addr = 16'h0000;
        bus.s3_req  = 1'b0; bus.s3_addr  = 16'h0000;
        bus.s5_req  = 1'b0; bus.s5_addr  = 16'h0000; bus.s5_wdata = 8'h00;
        @(negedge ram_clk);
        preload(16'h0004, 8'h02);
        preload(16'h0020, 8'h5A);
        preload(16'h0030, 8'h33);
        preload(16'h0060, 8'h11);
        preload(16'h0070, 8'h77);
        preload(16'h0080, 8'h88);
        preload(16'h0090, 8'h99);

        // reset state
        chk("rst_mem_we",    int'(bus.mem_we),    0);
        chk("rst_mem_addr",  int'(bus.mem_addr),  0);
        chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
        chk("rst_s12_ready", int'(bus.s12_ready), 0);
        chk("rst_s3_ready",  int'(bus.s3_ready),  0);
        chk("rst_s5_ready",  int'(bus.s5_ready),  0);
        chk("rst_s12_data",  int'(bus.s12_data),  0);
        chk("rst_s3_data",   int'(bus.s3_data),   0);
        rst = 1'b0;
        at_neg(cyc + 2);

        // single stage12 fetch
        k = cyc;
        bus.s12_addr = 16'h0004; bus.s12_req = 1'b1;
        push(12, 8'h02, k + 3);
        at_neg(k + 3); bus.s12_req = 1'b0;
        at_neg(cyc + 1);

        // write then read back the same location
        k = cyc;
        bus.s5_addr = 16'h0010; bus.s5_wdata = 8'hAB; bus.s5_req = 1'b1;
        push(5, 8'h00, k + 3);
        at_neg(k + 3); bus.s5_req = 1'b0;
        bus.s3_addr = 16'h0010; bus.s3_req = 1'b1;
        push(3, 8'hAB, k + 6);
        at_neg(k + 6); bus.s3_req = 1'b0;
        at_neg(cyc + 1);

        // all three at once: served s5, s3, s12
        k = cyc;
        bus.s12_addr = 16'h0070; bus.s3_addr = 16'h0080;
        bus.s5_addr = 16'h0012; bus.s5_wdata = 8'hCD;
        bus.s12_req = 1'b1; bus.s3_req = 1'b1; bus.s5_req = 1'b1;
        push(5, 8'h00, k + 3);
        push(3, 8'h88, k + 6);
        push(12, 8'h77, k + 9);
        at_neg(k + 3); bus.s5_req = 1'b0;
        at_neg(k + 6); bus.s3_req = 1'b0;
        at_neg(k + 9); bus.s12_req = 1'b0;
        at_neg(cyc + 1);

        // reset during an s3 read in ACCESS
        k = cyc;
        bus.s3_addr = 16'h0020; bus.s3_req = 1'b1;
        @(posedge ram_clk); #1;
        rst = 1'b1; bus.s3_req = 1'b0;
        #1;
        chk("rd_abort_mem_we",   int'(bus.mem_we),   0);
        chk("rd_abort_s3_ready", int'(bus.s3_ready), 0);
        chk("rd_abort_s3_data",  int'(bus.s3_data),  0);
        #1 rst = 1'b0;
        at_neg(k + 6);

        // reset during an s5 write: mem_we drops at once and nothing is committed
        k = cyc;
        bus.s5_addr = 16'h0060; bus.s5_wdata = 8'h66; bus.s5_req = 1'b1;
        @(posedge ram_clk); #1;
        chk("wr_pre_abort_mem_we", int'(bus.mem_we), 1);
        rst = 1'b1; bus.s5_req = 1'b0;
        #1;
        chk("wr_abort_mem_we",   int'(bus.mem_we),   0);
        chk("wr_abort_s5_ready", int'(bus.s5_ready), 0);
        #1 rst = 1'b0;
        at_neg(k + 6);

        // fresh s3 reads after reset complete in 3 cycles with old contents
        k = cyc;
        bus.s3_addr = 16'h0020; bus.s3_req = 1'b1;
        push(3, 8'h5A, k + 3);
        at_neg(k + 3); bus.s3_req = 1'b0;
        at_neg(cyc + 1);
        k = cyc;
        bus.s3_addr = 16'h0060; bus.s3_req = 1'b1;
        push(3, 8'h11, k + 3);
        at_neg(k + 3); bus.s3_req = 1'b0;
        at_neg(cyc + 1);

        // req held one cycle past ready: masked edge, then exactly one more access
        k = cyc;
        bus.s12_addr = 16'h0090; bus.s12_req = 1'b1;
        push(12, 8'h99, k + 3);
        push(12, 8'h99, k + 7);
        at_neg(k + 5); bus.s12_req = 1'b0;
        at_neg(k + 10);

        // continuous s3/s5 traffic against a waiting s12
        k = cyc;
        bus.s12_addr = 16'h0040; bus.s3_addr = 16'h0030;
        bus.s5_addr = 16'h0050; bus.s5_wdata = 8'h55;
        bus.s12_req = 1'b1; bus.s3_req = 1'b1; bus.s5_req = 1'b1;
        push(5, 8'h00, k + 3);
        push(3, 8'h33, k + 6);
        push(5, 8'h00, k + 9);
        push(3, 8'h33, k + 12);
`ifdef ARB_STARVE_GUARD_EN
        push(12, 8'h00, k + 15);
`else
        push(5, 8'h00, k + 15);
`endif
        at_neg(k + 13);
        bus.s3_req = 1'b0; bus.s5_req = 1'b0;
`ifndef ARB_STARVE_GUARD_EN
        bus.s12_req = 1'b0;
`endif
        at_neg(k + 15); bus.s12_req = 1'b0;
        at_neg(k + 22);

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
